branch_outcome_tracker: RTL and testbench
=========================================

BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

Interface
REQ-001 Parameter: DEPTH, default 4, number of in-flight prediction entries; SHALL be a power of two, 2..16.
REQ-002 Parameter: STAT_W, default 16, width of the misprediction statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pred_valid  input  1  a prediction was issued this cycle; request to push.
REQ-006 pred_bit  input  1  predicted direction (1 = taken) to store.
REQ-007 pred_ready  output  1  queue can accept a push (not full); combinational from state.
REQ-008 res_valid  input  1  the oldest outstanding branch resolved this cycle; request to pop.
REQ-009 res_taken  input  1  actual branch direction (1 = taken).
REQ-010 res_ready  output  1  queue holds at least one entry (not empty); combinational from state.
REQ-011 upd_result  output  1  registered one-cycle pulse: training update for the 2-bit counter predictor (drives its result input).
REQ-012 upd_taken  output  1  registered actual direction accompanying upd_result (drives predictor taken).
REQ-013 mispredict  output  1  registered one-cycle pulse: popped prediction differed from actual outcome.
REQ-014 count  output  $clog2(DEPTH)+1  current number of valid entries.
REQ-015 mispred_cnt  output  STAT_W  saturating total of mispredictions since reset.

Function
REQ-016 Storage SHALL be an in-order circular FIFO of DEPTH 1-bit prediction entries, with read/write pointers of $clog2(DEPTH)+1 bits (extra wrap bit); full = pointers differ only in the wrap bit, empty = pointers equal.
REQ-017 Push accepted iff pred_valid && pred_ready; pred_bit written at wr_ptr, wr_ptr increments modulo 2*DEPTH.
REQ-018 Pop accepted iff res_valid && res_ready; entry at rd_ptr compared to res_taken, rd_ptr increments.
REQ-019 pred_valid while full SHALL be ignored (no write, no pointer change); res_valid while empty SHALL be ignored and SHALL produce no update or mispredict pulse.
REQ-020 On accepted pop, next cycle: upd_result = 1, upd_taken = res_taken; otherwise both 0 (latency exactly 1 cycle).
REQ-021 On accepted pop with stored bit != res_taken, next cycle mispredict = 1; otherwise 0.
REQ-022 Mispredict flush: in the pop cycle of a mismatch, all younger entries SHALL be discarded (wr_ptr <= rd_ptr + 1), so count = 0 next cycle.
REQ-023 Simultaneous push and mismatching pop: flush wins; the same-cycle push SHALL be dropped (wrong-path prediction).
REQ-024 Simultaneous push and matching pop: both performed; count unchanged; legal when full (pop frees the slot only next cycle, so pred_ready stays 0 and push is not accepted when full).
REQ-025 mispred_cnt SHALL increment by 1 per mismatching pop and saturate at 2^STAT_W-1 (no wrap).
REQ-026 count = wr_ptr - rd_ptr (modulo 2*DEPTH), always 0..DEPTH.
REQ-027 Upd and mispredict pulses SHALL never last more than one cycle per accepted pop; back-to-back pops yield back-to-back pulses.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) clear pointers, count = 0, upd_result = 0, upd_taken = 0, mispredict = 0, mispred_cnt = 0; pred_ready = 1, res_ready = 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; no pulse emitted after reset for pre-reset pops.
REQ-030 Storage array contents need not be reset; they are unobservable while empty.

Verification
REQ-031 Fill: DEPTH=4, push 1,0,1,1 -> count 4, pred_ready 0; 5th push ignored, count stays 4.
REQ-032 In-order match: pop with res_taken 1,0,1,1 -> upd_result pulse each next cycle, upd_taken 1,0,1,1, mispredict never, mispred_cnt 0, res_ready 0 at end.
REQ-033 Flush: entries 1,1,0; pop with res_taken 0 -> mispredict 1 next cycle, count 0, mispred_cnt 1; simultaneous push in that cycle not stored.
REQ-034 Wrap: 10 push/pop pairs across pointer wrap with alternating values -> count correct every cycle, no spurious full/empty.
REQ-035 Saturation: STAT_W=2, 5 mispredicting pops -> mispred_cnt 3 after third, stays 3.
REQ-036 Async reset: assert rst_n=0 between clock edges with count 3 -> count 0, outputs 0 without a clock edge; pop on empty after release -> no pulse.

Source files
------------

// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker
//   In-order FIFO of outstanding branch predictions. Each resolved branch pops
//   the oldest prediction and compares it with the actual direction. The
//   comparison produces a registered training pulse for a 2-bit counter
//   predictor. On a misprediction it also produces a flush that discards all
//   younger (wrong-path) entries.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   pred_valid   push request (prediction issued)
//   pred_bit     predicted direction to store (1 = taken)
//   pred_ready   queue not full
//   res_valid    pop request (oldest branch resolved)
//   res_taken    actual direction (1 = taken)
//   res_ready    queue not empty
//   upd_result   one-cycle training pulse, one cycle after an accepted pop
//   upd_taken    actual direction accompanying upd_result
//   mispredict   one-cycle pulse: popped prediction differed from outcome
//   count        number of valid entries (0..DEPTH)
//   mispred_cnt  saturating misprediction total since reset
module branch_outcome_tracker #(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_bit,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_result,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STAT_W-1:0]        mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  logic [DEPTH-1:0]  entry_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              push_p0;
  logic              pop_p0;
  logic              mis_p0;
  logic              upd_result_p1;
  logic              upd_taken_p1;
  logic              mispredict_p1;
  logic [STAT_W-1:0] mispred_cnt_p1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign pred_ready = ~full;
  assign res_ready  = ~empty;
  assign count      = wr_ptr - rd_ptr;

  // Stage p0: accept decisions and comparison against the oldest entry
  assign push_p0 = pred_valid & ~full;
  assign pop_p0  = res_valid & ~empty;
  assign mis_p0  = pop_p0 & (entry_q[rd_ptr[AW-1:0]] != res_taken);

  // Storage is not reset: entries are only read while the queue is non-empty.
  // A push in a mispredicting cycle is wrong-path, so it is not written.
  always_ff @(posedge clk) begin
    if (push_p0 && !mis_p0)
      entry_q[wr_ptr[AW-1:0]] <= pred_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop_p0)
        rd_ptr <= rd_ptr + PTR_ONE;
      // Flush: the write pointer snaps to the new read pointer, dropping all
      // younger entries and any same-cycle push.
      if (mis_p0)
        wr_ptr <= rd_ptr + PTR_ONE;
      else if (push_p0)
        wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Stage p1: registered training/misprediction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_result_p1  <= 1'b0;
      upd_taken_p1   <= 1'b0;
      mispredict_p1  <= 1'b0;
      mispred_cnt_p1 <= '0;
    end else begin
      upd_result_p1 <= pop_p0;
      upd_taken_p1  <= pop_p0 & res_taken;
      mispredict_p1 <= mis_p0;
      if (mis_p0)
        mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
    end
  end

  assign upd_result  = upd_result_p1;
  assign upd_taken   = upd_taken_p1;
  assign mispredict  = mispredict_p1;
  assign mispred_cnt = mispred_cnt_p1;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
module tb_branch_outcome_tracker;

  localparam int DEPTH  = 4;
  localparam int STAT_W = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pred_valid = 1'b0;
  logic              pred_bit = 1'b0;
  logic              pred_ready;
  logic              res_valid = 1'b0;
  logic              res_taken = 1'b0;
  logic              res_ready;
  logic              upd_result;
  logic              upd_taken;
  logic              mispredict;
  logic [CW-1:0]     count;
  logic [STAT_W-1:0] mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected pulses: {upd_taken, mispredict}
  logic [1:0] sb[$];
  bit         model[$];

  branch_outcome_tracker #(.DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_bit(pred_bit), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_result(upd_result), .upd_taken(upd_taken), .mispredict(mispredict),
    .count(count), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input bit pv, input bit pb, input bit rv, input bit rt,
                     input bit exp_pop, input bit exp_mis);
    pred_valid = pv; pred_bit = pb; res_valid = rv; res_taken = rt;
    if (exp_pop) sb.push_back({rt, exp_mis});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: consumes one expected entry per training pulse.
  always @(negedge clk) begin
    logic [1:0] e;
    if (upd_result === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_upd", upd_result, 0);
      end else begin
        e = sb.pop_front();
        chk("upd_taken", upd_taken, e[1]);
        chk("mispredict", mispredict, e[0]);
      end
    end else begin
      chk("idle_outputs", {upd_result, upd_taken, mispredict}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fv[4] = '{1, 0, 1, 1};
    bit rt;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_pred_ready", pred_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill to DEPTH, then an ignored push
    for (int i = 0; i < 4; i++) begin
      cyc(1, fv[i], 0, 0, 0, 0);
      chk("fill_count", count, i + 1);
    end
    chk("full_pred_ready", pred_ready, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("overfill_count", count, 4);

    // In-order matching pops
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, fv[i], 1, 0);
      chk("pop_count", count, 3 - i);
    end
    chk("empty_res_ready", res_ready, 0);
    chk("match_mispred_cnt", mispred_cnt, 0);
    cyc(0, 0, 1, 1, 0, 0);  // pop on empty: no pulse expected
    drain();

    // Mispredict flush with a same-cycle push
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("flush_pre_count", count, 3);
    cyc(1, 1, 1, 0, 1, 1);
    chk("flush_count", count, 0);
    chk("flush_res_ready", res_ready, 0);
    chk("flush_mispred_cnt", mispred_cnt, 1);
    drain();

    // Pointer wrap: steady push/pop pairs with one entry in flight
    cyc(1, 0, 0, 0, 0, 0);
    model.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin
      rt = model.pop_front();
      model.push_back(bit'(i % 2));
      cyc(1, bit'(i % 2), 1, rt, 1, 0);
      chk("wrap_count", count, 1);
      chk("wrap_pred_ready", pred_ready, 1);
      chk("wrap_res_ready", res_ready, 1);
    end

    // Full with simultaneous push and matching pop: push refused
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      model.push_back(1'b0);
    end
    chk("refill_count", count, 4);
    rt = model.pop_front();
    cyc(1, 0, 1, rt, 1, 0);
    chk("full_pushpop_count", count, 3);
    chk("full_pushpop_ready", pred_ready, 1);
    while (model.size() > 0) begin
      rt = model.pop_front();
      cyc(0, 0, 1, rt, 1, 0);
    end
    chk("wrap_end_count", count, 0);
    drain();

    // Asynchronous reset mid-operation with three entries
    for (int i = 0; i < 4; i++) cyc(1, fv[i], 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    pred_valid = 0; res_valid = 0;
    chk("prereset_count", count, 3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("areset_count", count, 0);
    chk("areset_pred_ready", pred_ready, 1);
    chk("areset_res_ready", res_ready, 0);
    chk("areset_pulses", {upd_result, upd_taken, mispredict}, 0);
    chk("areset_mispred_cnt", mispred_cnt, 0);
    #1 rst_n = 1'b1;
    cyc(0, 0, 1, 1, 0, 0);
    chk("postreset_count", count, 0);
    drain();

    // Saturating statistics (STAT_W = 2)
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 1);
      chk("sat_mispred_cnt", mispred_cnt, (k > 3) ? 3 : k);
      chk("sat_count", count, 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
